// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce input conditioner.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package debounce_pkg;

    // Filter FSM states: two settled levels and two qualifying states.
    typedef enum logic [1:0] {
        HIGH     = 2'd0,
        CHK_LOW  = 2'd1,
        LOW      = 2'd2,
        CHK_HIGH = 2'd3
    } state_t;

    // Level the line rests at when nobody is pressing it.
    localparam logic IDLE_LEVEL = 1'b1;

    // Width able to hold max(a, b) inclusive, so a counter can saturate at it.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return ((m + 1) <= 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/debounce_if.sv
// Bundles the raw input line and the conditioned level/strobe outputs.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are plain levels or one-cycle strobes.
interface debounce_if;
    logic din;
    logic dout;
    logic fall;
    logic rise;
    logic long_press;

    // Producer of the raw line, consumer of the conditioned outputs.
    modport master (
        output din,
        input  dout,
        input  fall,
        input  rise,
        input  long_press
    );

    // The conditioner itself.
    modport slave (
        input  din,
        output dout,
        output fall,
        output rise,
        output long_press
    );
endinterface

// File: rtl/debounce_sync_chain.sv
// Metastability synchronizer: shift chain of SYNC_STAGES flops, q is the last stage.
// Latency: SYNC_STAGES cycles from d to q.
// Backpressure: none; samples d every cycle.
module sync_chain #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the asynchronous input through the chain; reset fills it with RST_VAL.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {SYNC_STAGES{RST_VAL}};
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/debounce.sv
// Debounce filter: synchronizer + counter-qualified FSM, registered level and edge strobes.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES cycles from a stable din edge to dout/strobe.
// Backpressure: none. Optional hold detector under `DEBOUNCE_LONGPRESS_EN (long_press tied 0 otherwise).
module debounce
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    debounce_if.slave  bus
);

    localparam int            CW      = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s;
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic          done;
    logic          dout_q, dout_nxt;
    logic          fall_q, fall_nxt;
    logic          rise_q, rise_nxt;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (IDLE_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.din),
        .q   (s)
    );

    // cnt holds how many consecutive cycles the opposite level has already been
    // seen, so the cycle that would make it DEBOUNCE_CYCLES flips the output.
    // The first differing cycle is counted from the settled state itself, which
    // gives exactly SYNC_STAGES + DEBOUNCE_CYCLES latency and lets a count of 1
    // switch on the very first differing cycle.
    assign done    = (cnt == DB_LAST);
    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= HIGH;
            cnt    <= '0;
            dout_q <= IDLE_LEVEL;
            fall_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            dout_q <= dout_nxt;
            fall_q <= fall_nxt;
            rise_q <= rise_nxt;
        end
    end

    // Next-state logic: qualify a level change over DEBOUNCE_CYCLES cycles.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dout_nxt  = dout_q;
        fall_nxt  = 1'b0;
        rise_nxt  = 1'b0;
        unique case (state)
            HIGH: begin
                cnt_nxt = '0;
                if (!s) begin
                    if (done) begin
                        state_nxt = LOW;
                        dout_nxt  = 1'b0;
                        fall_nxt  = 1'b1;
                    end else begin
                        state_nxt = CHK_LOW;
                        cnt_nxt   = cnt_inc;
                    end
                end
            end
            CHK_LOW: begin
                if (s) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                end else if (done) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                    dout_nxt  = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            LOW: begin
                cnt_nxt = '0;
                if (s) begin
                    if (done) begin
                        state_nxt = HIGH;
                        dout_nxt  = 1'b1;
                        rise_nxt  = 1'b1;
                    end else begin
                        state_nxt = CHK_HIGH;
                        cnt_nxt   = cnt_inc;
                    end
                end
            end
            CHK_HIGH: begin
                if (!s) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                end else if (done) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                    dout_nxt  = 1'b1;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = HIGH;
                cnt_nxt   = '0;
                dout_nxt  = IDLE_LEVEL;
            end
        endcase
    end

    assign bus.dout = dout_q;
    assign bus.fall = fall_q;
    assign bus.rise = rise_q;

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] LONG_END  = CW'(LONG_CYCLES);

    logic [CW-1:0] hold;
    logic          long_q;
    logic          held_low;

    // A CHK_HIGH excursion still counts as held; only a qualified release clears.
    assign held_low = (state == LOW) || (state == CHK_HIGH);

    // Hold counter: runs while held low, fires once at LONG_CYCLES-1, then parks.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold   <= '0;
            long_q <= 1'b0;
        end else if (held_low) begin
            hold   <= (hold == LONG_END) ? hold : hold + 1'b1;
            long_q <= (hold == LONG_LAST);
        end else begin
            hold   <= '0;
            long_q <= 1'b0;
        end
    end

    assign bus.long_press = long_q;
`else
    assign bus.long_press = 1'b0;
`endif

endmodule
